// File: rtl/spi_sum_slave.sv
// -----------------------------------------------------------------------------
// spi_sum_slave
//
// SPI slave that oversamples the SPI pins in the clk_i domain and deserialises
// MSB-first bytes. Each completed byte is presented on rx_data_o with a
// one-cycle rx_valid_o pulse. While selected, it shifts back the 8-bit sum of
// the two most recently completed bytes.
//
// Optional feature macro: SPI_SUM_SAT_EN
//   defined   -> the running sum saturates at 8'hFF
//   undefined -> the running sum wraps modulo 256
//
// Ports:
//   clk_i        in   system clock, rising edge
//   reset_ni     in   asynchronous active-low reset
//   ss_ni        in   slave select, active low (asynchronous)
//   sclk_i       in   SPI clock (asynchronous)
//   mosi_i       in   serial data from master (asynchronous)
//   cpol_i       in   clock polarity, latched at frame start
//   cpha_i       in   clock phase, latched at frame start
//   miso_o       out  serial response, MSB first, 0 while deselected
//   rx_data_o    out  last completed received byte
//   rx_valid_o   out  one-cycle pulse when rx_data_o updates
//   frame_err_o  out  one-cycle pulse when ss_ni rises mid-byte
// -----------------------------------------------------------------------------
module spi_sum_slave #(
  parameter int CLK_PER_SCLK_MIN = 8
) (
  input  logic       clk_i,
  input  logic       reset_ni,
  input  logic       ss_ni,
  input  logic       sclk_i,
  input  logic       mosi_i,
  input  logic       cpol_i,
  input  logic       cpha_i,
  output logic       miso_o,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  output logic       frame_err_o
);

  // The synchroniser plus edge-detect path needs a few clk cycles per sclk
  // half period; reject configurations that cannot work.
  if (CLK_PER_SCLK_MIN < 4) begin : g_bad_cfg
    $error("spi_sum_slave: CLK_PER_SCLK_MIN must be at least 4");
  end

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_ACTIVE = 2'd2
  } state_e;

  // 8-bit sum of two bytes, wrapping or saturating depending on the build.
  function automatic logic [7:0] sum8(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b};
`ifdef SPI_SUM_SAT_EN
    if (s[8]) begin
      return 8'hFF;
    end else begin
      return s[7:0];
    end
`else
    return s[7:0];
`endif
  endfunction

  // Synchronisers and edge-detect delay flops
  logic ss_meta_q, ss_sync_q, ss_dly_q;
  logic sclk_meta_q, sclk_sync_q, sclk_dly_q;
  logic mosi_meta_q, mosi_sync_q, mosi_dly_q;

  // Control and datapath state
  state_e     state_q, state_d;
  logic       cpol_q, cpol_d;
  logic       cpha_q, cpha_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [6:0] rx_shift_q, rx_shift_d;
  logic [7:0] tx_shift_q, tx_shift_d;
  logic [7:0] sum_q, sum_d;
  logic [7:0] prev_q, prev_d;
  logic       done_q, done_d;

  // Registered outputs
  logic       miso_q, miso_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       frame_err_q, frame_err_d;

  logic       ss_fall_s, ss_rise_s;
  logic       sclk_chg_s, lead_s, trail_s;
  logic       sample_s, shift_s;
  logic [7:0] byte_s, sum_new_s;

  assign ss_fall_s  = ss_dly_q & ~ss_sync_q;
  assign ss_rise_s  = ~ss_dly_q & ss_sync_q;
  assign sclk_chg_s = sclk_sync_q ^ sclk_dly_q;
  // Leading edge leaves the idle (CPOL) level, trailing edge returns to it.
  assign lead_s     = sclk_chg_s & (sclk_sync_q != cpol_q);
  assign trail_s    = sclk_chg_s & (sclk_sync_q == cpol_q);
  assign sample_s   = cpha_q ? trail_s : lead_s;
  assign shift_s    = cpha_q ? lead_s : trail_s;
  // mosi_dly_q is the data value just before the detected sclk edge.
  assign byte_s     = {rx_shift_q, mosi_dly_q};
  assign sum_new_s  = sum8(byte_s, prev_q);

  // Next-state logic for the frame FSM, shift registers and outputs.
  always_comb begin
    state_d     = state_q;
    cpol_d      = cpol_q;
    cpha_d      = cpha_q;
    bit_cnt_d   = bit_cnt_q;
    rx_shift_d  = rx_shift_q;
    tx_shift_d  = tx_shift_q;
    sum_d       = sum_q;
    prev_d      = prev_q;
    done_d      = 1'b0;
    miso_d      = miso_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;

    // The completed byte was captured into prev_q one cycle earlier; publish
    // it now so rx_valid_o lines up with the registered miso timing.
    if (done_q) begin
      rx_data_d  = prev_q;
      rx_valid_d = 1'b1;
    end else begin
      rx_data_d  = rx_data_q;
    end

    case (state_q)
      ST_IDLE: begin
        bit_cnt_d = 3'd0;
        miso_d    = 1'b0;
        if (ss_fall_s) begin
          state_d = ST_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_LOAD: begin
        cpol_d     = cpol_i;
        cpha_d     = cpha_i;
        tx_shift_d = sum_q;
        bit_cnt_d  = 3'd0;
        if (ss_rise_s) begin
          state_d = ST_IDLE;
          miso_d  = 1'b0;
        end else begin
          state_d = ST_ACTIVE;
          miso_d  = sum_q[7];
        end
      end

      ST_ACTIVE: begin
        miso_d = tx_shift_q[7];
        if (sample_s) begin
          bit_cnt_d  = bit_cnt_q + 3'd1;
          rx_shift_d = byte_s[6:0];
          if (bit_cnt_q == 3'd7) begin
            // Reload tx so a following byte in the same frame starts with
            // the fresh sum's MSB.
            done_d     = 1'b1;
            prev_d     = byte_s;
            sum_d      = sum_new_s;
            tx_shift_d = sum_new_s;
          end else begin
            done_d     = 1'b0;
          end
        end else if (shift_s && (bit_cnt_q != 3'd0)) begin
          // At a byte boundary the MSB is already on the line, so the shift
          // edge that would otherwise push it out is skipped.
          tx_shift_d = {tx_shift_q[6:0], 1'b0};
        end else begin
          tx_shift_d = tx_shift_q;
        end

        if (ss_rise_s) begin
          // A byte completing on the same cycle leaves bit_cnt_d at 0,
          // so it is not flagged as an error.
          state_d     = ST_IDLE;
          miso_d      = 1'b0;
          bit_cnt_d   = 3'd0;
          frame_err_d = (bit_cnt_q + {2'd0, sample_s}) != 3'd0;
        end else begin
          state_d     = ST_ACTIVE;
        end
      end

      default: begin
        state_d   = ST_IDLE;
        bit_cnt_d = 3'd0;
        miso_d    = 1'b0;
      end
    endcase
  end

  // All flops: synchronisers, FSM state, datapath and registered outputs.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      // ss synchroniser resets to "selected" so that a slave select still
      // held low across reset release never looks like a fresh falling edge.
      ss_meta_q   <= 1'b0;
      ss_sync_q   <= 1'b0;
      ss_dly_q    <= 1'b0;
      sclk_meta_q <= 1'b0;
      sclk_sync_q <= 1'b0;
      sclk_dly_q  <= 1'b0;
      mosi_meta_q <= 1'b0;
      mosi_sync_q <= 1'b0;
      mosi_dly_q  <= 1'b0;
      state_q     <= ST_IDLE;
      cpol_q      <= 1'b0;
      cpha_q      <= 1'b0;
      bit_cnt_q   <= 3'd0;
      rx_shift_q  <= 7'd0;
      tx_shift_q  <= 8'd0;
      sum_q       <= 8'd0;
      prev_q      <= 8'd0;
      done_q      <= 1'b0;
      miso_q      <= 1'b0;
      rx_data_q   <= 8'd0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      ss_meta_q   <= ss_ni;
      ss_sync_q   <= ss_meta_q;
      ss_dly_q    <= ss_sync_q;
      sclk_meta_q <= sclk_i;
      sclk_sync_q <= sclk_meta_q;
      sclk_dly_q  <= sclk_sync_q;
      mosi_meta_q <= mosi_i;
      mosi_sync_q <= mosi_meta_q;
      mosi_dly_q  <= mosi_sync_q;
      state_q     <= state_d;
      cpol_q      <= cpol_d;
      cpha_q      <= cpha_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_shift_q  <= rx_shift_d;
      tx_shift_q  <= tx_shift_d;
      sum_q       <= sum_d;
      prev_q      <= prev_d;
      done_q      <= done_d;
      miso_q      <= miso_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign miso_o      = miso_q;
  assign rx_data_o   = rx_data_q;
  assign rx_valid_o  = rx_valid_q;
  assign frame_err_o = frame_err_q;

endmodule

// File: doc/spi_sum_slave.md
# spi_sum_slave

- SPI slave endpoint that sits directly downstream of the SPI master, on the far side of its `sclk`/`mosi`/`miso`/`ss_n` pins.
- Oversamples the SPI pins in the system clock domain and deserialises each MSB-first byte.
- Presents each received byte on a parallel port with a one-cycle valid pulse.
- During each frame, shifts back the 8-bit sum of the two most recently completed bytes; this is the master's loop-back partner in the SPI subsystem.

## Interface
- `CLK_PER_SCLK_MIN`, default 8: minimum clk cycles per sclk period the block supports; documentation and assertion only, no logic effect.
- `clk_i`  in  1  system clock; all logic on its rising edge.
- `reset_ni`  in  1  asynchronous, active-low reset; deassertion is synchronous to `clk_i`.
- `ss_ni`  in  1  slave select, active low, asynchronous to `clk_i`.
- `sclk_i`  in  1  SPI clock from the master, asynchronous.
- `mosi_i`  in  1  serial data from the master, asynchronous.
- `cpol_i`  in  1  clock polarity; sampled when a frame starts.
- `cpha_i`  in  1  clock phase; sampled when a frame starts.
- `miso_o`  out  1  serial response, MSB first; 0 while deselected.
- `rx_data_o`  out  8  last completed received byte; held until the next byte completes.
- `rx_valid_o`  out  1  one-cycle pulse when `rx_data_o` updates.
- `frame_err_o`  out  1  one-cycle pulse when `ss_ni` rises mid-byte.

## Operation
- **Synchronisers:** `ss_ni`, `sclk_i` and `mosi_i` each pass through 2 flops, then 1 delay flop for edge detection.
- **Edge definitions:** a leading edge moves the synchronised sclk away from the latched CPOL level; a trailing edge moves it back.
- **FSM states:** IDLE, LOAD, ACTIVE.
- **IDLE:**
  - `miso_o` = 0 and the bit counter is held at 0.
  - A synchronised falling edge of ss → LOAD.
- **LOAD (1 cycle):**
  - Latch `cpol_i`/`cpha_i`.
  - Load tx_shift = sum_reg.
  - Drive `miso_o` = tx_shift[7].
  - Go to ACTIVE.
- **ACTIVE, CPHA=0:** sample mosi on the leading edge; shift tx on the trailing edge.
- **ACTIVE, CPHA=1:** shift tx on the leading edge (the first leading edge keeps the MSB already driven); sample mosi on the trailing edge.
- **Bit counter:** 3 bits, incremented per sample, wraps 7→0.
- **On the 8th sample:**
  - rx_data_o = assembled byte.
  - Pulse `rx_valid_o`.
  - sum_reg = byte + prev_byte.
  - prev_byte = byte.
  - tx_shift = new sum_reg, so the next byte within the same `ss_ni` low period starts with the new MSB.
- **Sum width:** 8+8 → 8 bits, wraps modulo 256 unless saturation is configured.
- **Response sequence:** byte N is answered with rx[N-1] + rx[N-2]; the history starts at 0, so byte 1 gets 0x00 and byte 2 gets rx[1].
- **Synchronised ss rise:**
  - Return to IDLE.
  - If the bit counter ≠ 0: discard the partial byte, pulse `frame_err_o`, and leave sum_reg/prev_byte unchanged.
- **ss rise coinciding with the 8th sample:** the byte completes normally and `frame_err_o` stays 0.
- **Ignored inputs:** sclk edges while in IDLE or LOAD, and `cpol_i`/`cpha_i` changes mid-frame.
- **Reset asserted mid-frame:** all state clears immediately; after release the block waits for a fresh falling edge of ss.

## Timing
- **Reset values:**
  - `miso_o` 0, `rx_data_o` 0x00, `rx_valid_o` 0, `frame_err_o` 0.
  - Internal sum_reg 0, prev_byte 0, FSM IDLE.
- **Pin-to-action latency:** 3 clk cycles from a pin edge to the internal action.
- **miso latency:** `miso_o` is registered and changes 4 clk cycles after the shift edge at the pin.
- **rx_valid latency:** `rx_valid_o` asserts 4 clk cycles after the 8th sample edge at the pin.
- **Start of frame:** the MSB is valid on `miso_o` 4 clk cycles after `ss_ni` falls; the master must leave at least 5 clk cycles before the first sclk edge.
- **sclk period:** ≥ `CLK_PER_SCLK_MIN` clk cycles. The master's dvsr=9 gives 20 cycles, which is compliant.
- **Outputs:** all glitch-free and registered.

## Configuration
- `SPI_SUM_SAT_EN` defined: sum_reg saturates at 0xFF when the 9-bit sum is > 255.
- `SPI_SUM_SAT_EN` undefined: the sum wraps modulo 256.
- No other behaviour differs.

## Test plan
- **Reset then idle:**
  - Stimulus: hold `reset_ni`=0 for 2 cycles, release, keep `ss_ni`=1.
  - Required: `miso_o`=0, `rx_data_o`=0x00, no pulses for 100 cycles.
- **Mode 0, dvsr=9:**
  - Stimulus: master sends 0x00, 0x01, 0x02, 0x03, 0x04, 0x05 in separate frames.
  - Required: `rx_data_o` sequence 00..05 with 6 `rx_valid_o` pulses.
  - Required: master receives 0x00, 0x00, 0x01, 0x03, 0x05, 0x07.
- **Modes 1/2/3:**
  - Stimulus: send 0xA5 then 0x5A in each mode.
  - Required: rx matches the bytes sent, and the second response = 0xA5.
- **Wrap vs saturation:**
  - Stimulus: send 0xF0, 0x20, then any byte.
  - Required: the third response is 0x10 without the macro, 0xFF with `SPI_SUM_SAT_EN`.
- **Aborted frame:**
  - Stimulus: send 0x11, then raise `ss_ni` after 4 bits, then send 0x22.
  - Required: one `frame_err_o` pulse.
  - Required: the response to 0x22 = 0x11 + 0x00 = 0x11; `rx_data_o` never shows a partial byte.
- **Reset mid-frame:**
  - Stimulus: assert `reset_ni` after bit 3 of 0x7E, then send 0x33.
  - Required: all outputs 0 during reset; the response to 0x33 = 0x00.
